// File: rtl/rom_read_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous ROM.
// One read is in flight at a time: accept -> ISSUE (chip-select pulse) ->
// WAIT (READ_LATENCY edges) -> RESP (hold until consumed) -> IDLE.
// READ_LATENCY must lie in 1..7 so that it fits the 3-bit latency counter.
module rom_read_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req0_valid,
    input  logic [9:0] req0_addr,
    input  logic       req1_valid,
    input  logic [9:0] req1_addr,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       rom_cs,
    output logic [9:0] rom_addr,
    input  logic [7:0] rom_dout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       rom_cs_q, rom_cs_d;
    logic [9:0] rom_addr_q, rom_addr_d;
    logic       rsp0_valid_q, rsp0_valid_d;
    logic       rsp1_valid_q, rsp1_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_id_q, grant_id_d;

    logic       grant_any;
    logic       win1;

    // Arbitration: requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    always_comb begin
        win1       = req1_valid && (!req0_valid || (last_grant_q == 1'b0));
        grant_any  = (state_q == IDLE) && en && (req0_valid || req1_valid);
        req0_ready = grant_any && !win1;
        req1_ready = grant_any && win1;
    end

    // Next-state and datapath updates for the access sequence.
    always_comb begin
        state_d      = state_q;
        rom_cs_d     = rom_cs_q;
        rom_addr_d   = rom_addr_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp_data_d   = rsp_data_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    rom_addr_d   = win1 ? req1_addr : req0_addr;
                    rom_cs_d     = 1'b1;
                    last_grant_d = win1;
                    grant_id_d   = win1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // The ROM samples rom_cs/rom_addr at this edge; start counting its latency.
                rom_cs_d = 1'b0;
                cnt_d    = 3'(READ_LATENCY);
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter reaches zero at this edge: ROM data is valid now.
                if (cnt_q <= 3'd1) begin
                    cnt_d        = 3'd0;
                    rsp_data_d   = rom_dout;
                    rsp0_valid_d = !grant_id_q;
                    rsp1_valid_d = grant_id_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight read immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= 10'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= 8'd0;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_cs_q     <= rom_cs_d;
            rom_addr_q   <= rom_addr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign rom_cs     = rom_cs_q;
    assign rom_addr   = rom_addr_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);

endmodule
